debounce_scan_scheduler: RTL and testbench
==========================================

// Module: debounce_scan_scheduler
// PURPOSE
//  Debounces N_BTN raw push-button inputs with one shared debounce engine and one shared tick prescaler.
//  A round-robin scanner visits one channel per clock and applies the shared next-state logic to that
//  channel's stored state. Sits between the board button pins and the user-logic FSMs; replaces one
//  debouncer-plus-prescaler per button.
// PARAMETERS
//  N_BTN        4          number of button channels (2..16)
//  TICK_DIV     1_000_000  clk cycles per debounce tick (10 ms at 100 MHz); must be >= 2*N_BTN
//  STABLE_TICKS 3          consecutive ticks a changed level must persist before it is accepted (1..7)
// PORTS
//  clk     in   1      system clock, 100 MHz
//  reset   in   1      synchronous, active-high reset
//  btn     in   N_BTN  raw asynchronous button levels
//  deb     out  N_BTN  debounced levels
//  rise    out  N_BTN  one-cycle pulse when deb[i] goes 0->1
//  fall    out  N_BTN  one-cycle pulse when deb[i] goes 1->0
//  tick    out  1      debug: one-cycle prescaler tick
// BEHAVIOUR
//  Interface: one clock, clk. reset is synchronous and active-high.
//  Reset: synchronous, active-high. Clears all state: deb=0, rise=0, fall=0, tick=0, all per-channel
//   counts=0, scan index=0, prescaler=0, tick_pending=0, pass_tick=0, 2-flop synchronisers=0.
//   Reset asserted mid-operation discards in-progress counts; the first valid scan starts the cycle after
//   reset deasserts.
//  Sync: each btn[i] passes through a 2-flop synchroniser; s_btn[i] is the synchronised level.
//  Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for the one cycle the count wraps to 0. Free-running.
//  Tick pending: tick sets tick_pending. At the start of a pass (idx==0), pass_tick<=tick_pending and
//   tick_pending is cleared. If tick is set in that same cycle, tick_pending stays 1 and applies to the
//   next pass. Every channel therefore sees each tick exactly once.
//  Scanner: idx cycles 0,1,..,N_BTN-1,0 continuously, one channel per clk. A pass is N_BTN cycles.
//  Per-channel state: lvl[i] (=deb[i]) and cnt[i] (width clog2(STABLE_TICKS+1)). When idx==i:
//   - s_btn[i]==lvl[i]: cnt[i]<=0. This is a bounce cancel, equivalent to returning to the stable state.
//   - s_btn[i]!=lvl[i], pass_tick==0: cnt[i] holds.
//   - s_btn[i]!=lvl[i], pass_tick==1, cnt[i]+1<STABLE_TICKS: cnt[i]<=cnt[i]+1.
//   - s_btn[i]!=lvl[i], pass_tick==1, cnt[i]+1==STABLE_TICKS: lvl[i]<=s_btn[i]; cnt[i]<=0;
//     rise[i] or fall[i] pulses high for exactly one cycle (the cycle deb[i] changes).
//  Same rule in both directions: press and release use a symmetric 0->1 / 1->0 filter.
//  Latency from a btn edge held stable to the deb change: at least (STABLE_TICKS-1)*TICK_DIV cycles and
//   at most STABLE_TICKS*TICK_DIV + 2*N_BTN + 3 cycles.
//  Glitch: any return of s_btn[i] to lvl[i] at channel i's scan slot resets cnt[i] to 0.
//   A glitch shorter than one pass may go unseen; that is acceptable.
//  Outputs are registered. rise/fall are never both high for the same channel. At most one channel
//   changes per cycle.
// STRUCTURE
//  Package debounce_pkg:
//   - CLK_HZ=100_000_000
//   - TICK_10MS_DIV=CLK_HZ/100
//   - function clog2
//  Sub-module tick_prescaler:
//   - params DIV; ports clk, reset, tick
//   - reusable by other timing blocks
//  Top level: synchroniser array, scan index counter, pending/pass_tick logic, cnt/lvl register arrays,
//   shared next-state logic muxed by idx.
// TESTING  (bench uses N_BTN=4, TICK_DIV=16, STABLE_TICKS=3)
//  1. Reset 5 cycles, btn=0 -> deb=0, rise=fall=0, tick first pulses 16 cycles after reset release.
//  2. btn[0]=1 held -> rise[0] single pulse, deb[0]=1 within 32..59 cycles. Other channels stay 0.
//  3. btn[1] 0->1 for 20 cycles, then 0 -> no rise[1], deb[1] stays 0. cnt[1] returns to 0 (white-box).
//  4. btn[0]=1 stable, then btn[0]=0 held -> fall[0] single pulse within 32..59 cycles, deb[0]=0.
//  5. All four btn rise in the same cycle -> all deb=1. The rise pulses land on 4 distinct consecutive cycles.
//  6. btn[2]=1 held, reset pulsed after 2 ticks -> deb=0; deb[2] rises a full 32..59 cycles after release.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the button debounce / timing blocks.
package debounce_pkg;

  localparam int CLK_HZ        = 100_000_000;
  localparam int TICK_10MS_DIV = CLK_HZ / 100;

  // Bits needed to hold values 0..v-1 (at least 1).
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high for the single cycle in which the count wraps to 0.
module tick_prescaler
  import debounce_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = clog2(DIV);

  logic [W-1:0] cnt_q;
  logic         tick_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == W'(DIV - 1)) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/debounce_scan_scheduler.sv
// Time-multiplexed debouncer: one shared filter engine visits one button channel per clock
// in round-robin order, driven by a single shared tick prescaler.
module debounce_scan_scheduler
  import debounce_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = TICK_10MS_DIV,
  parameter int STABLE_TICKS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] deb,
  output logic [N_BTN-1:0] rise,
  output logic [N_BTN-1:0] fall,
  output logic             tick
);

  localparam int IW = clog2(N_BTN);
  localparam int CW = clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_TICKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BTN - 1);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [IW-1:0]    idx_q;
  logic             tick_pending_q, pass_tick_q;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [N_BTN-1:0] lvl_q, rise_q, fall_q;

  logic          tick_w;
  logic          sel_btn, sel_lvl, pass_tick_eff;
  logic [CW-1:0] sel_cnt, cnt_d;
  logic          lvl_d, edge_d;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick_w)
  );

  // Channel 0 is scanned in the same cycle pass_tick is loaded, so it reads the pending flag
  // directly; the rest of the pass reads the latched copy, giving every channel the same tick.
  assign pass_tick_eff = (idx_q == '0) ? tick_pending_q : pass_tick_q;
  assign sel_btn       = sync2_q[idx_q];
  assign sel_lvl       = lvl_q[idx_q];
  assign sel_cnt       = cnt_q[idx_q];

  always_comb begin
    cnt_d  = sel_cnt;
    lvl_d  = sel_lvl;
    edge_d = 1'b0;
    if (sel_btn == sel_lvl) begin
      cnt_d = '0;
    end else if (pass_tick_eff) begin
      if (sel_cnt + 1'b1 == STABLE_C) begin
        cnt_d  = '0;
        lvl_d  = sel_btn;
        edge_d = 1'b1;
      end else begin
        cnt_d = sel_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      idx_q          <= '0;
      tick_pending_q <= 1'b0;
      pass_tick_q    <= 1'b0;
      lvl_q          <= '0;
      rise_q         <= '0;
      fall_q         <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      idx_q   <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

      if (idx_q == '0) begin
        pass_tick_q    <= tick_pending_q;
        tick_pending_q <= tick_w;
      end else begin
        tick_pending_q <= tick_pending_q | tick_w;
      end

      cnt_q[idx_q]  <= cnt_d;
      lvl_q[idx_q]  <= lvl_d;
      rise_q        <= '0;
      fall_q        <= '0;
      rise_q[idx_q] <= edge_d & lvl_d;
      fall_q[idx_q] <= edge_d & ~lvl_d;
    end
  end

  assign deb  = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign tick = tick_w;

endmodule

// File: tb/tb_debounce_scan_scheduler.sv
// Directed bench for debounce_scan_scheduler: expected edge events go into a queue that a
// negedge monitor pops whenever the DUT pulses rise or fall.
module tb_debounce_scan_scheduler;

  localparam int N_BTN   = 4;
  localparam int DIV     = 16;
  localparam int ST      = 3;
  localparam int LAT_MIN = (ST - 1) * DIV;
  localparam int LAT_MAX = ST * DIV + 2 * N_BTN + 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_BTN-1:0] btn = '0;
  logic [N_BTN-1:0] deb, rise, fall;
  logic             tick;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rel;
  int ev_cyc [N_BTN];

  // Event code: {is_fall, channel[3:0]}; exp_t_q holds the cycle the stimulus was applied.
  logic [4:0] exp_q [$];
  int         exp_t_q [$];

  debounce_scan_scheduler #(
    .N_BTN(N_BTN), .TICK_DIV(DIV), .STABLE_TICKS(ST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .deb  (deb),
    .rise (rise),
    .fall (fall),
    .tick (tick)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_btn(input logic [N_BTN-1:0] v);
    @(posedge clk);
    #1 btn = v;
  endtask

  task automatic expect_edge(input int ch, input logic is_fall, input int t);
    exp_q.push_back({is_fall, 4'(ch)});
    exp_t_q.push_back(t);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout_pending_events", exp_q.size(), 0);
      exp_q.delete();
      exp_t_q.delete();
    end
  endtask

  task automatic wait_tick(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < budget);
    if (!tick) check("tick_timeout", 0, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && ((rise | fall) != '0)) begin
      check("one_channel_per_cycle", $countones(rise | fall), 1);
      for (int ch = 0; ch < N_BTN; ch++) begin
        if (rise[ch] || fall[ch]) begin
          logic [4:0] got;
          got = {fall[ch], 4'(ch)};
          ev_cyc[ch] = cyc;
          check("rise_fall_exclusive", int'(rise[ch] & fall[ch]), 0);
          if (exp_q.size() == 0) begin
            check("unexpected_edge_event", int'(got), 'h1f);
          end else begin
            logic [4:0] want;
            int         t0;
            want = exp_q.pop_front();
            t0   = exp_t_q.pop_front();
            check("edge_event", int'(got), int'(want));
            check_range("edge_latency", cyc - t0, LAT_MIN, LAT_MAX);
            check("deb_matches_edge", int'(deb[ch]), int'(rise[ch]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // 1: reset state and first prescaler tick
    reset = 1'b1;
    btn   = '0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    rel = cyc;
    @(negedge clk);
    check("reset_deb", int'(deb), 0);
    check("reset_rise", int'(rise), 0);
    check("reset_fall", int'(fall), 0);
    check("reset_tick", int'(tick), 0);
    wait_tick(40);
    check("first_tick_delay", cyc - rel, DIV);

    // 2: press on channel 0
    drive_btn(4'b0001);
    expect_edge(0, 1'b0, cyc);
    wait_drain(100);
    @(negedge clk);
    check("press0_deb", int'(deb), 'b0001);
    check("press0_rise_single", int'(rise), 0);

    // 3: 20-cycle bounce on channel 1 must be rejected
    drive_btn(4'b0011);
    repeat (20) @(posedge clk);
    drive_btn(4'b0001);
    repeat (80) @(negedge clk);
    check("bounce1_deb", int'(deb), 'b0001);
    check("bounce1_cnt", int'(dut.cnt_q[1]), 0);

    // 4: release on channel 0
    drive_btn(4'b0000);
    expect_edge(0, 1'b1, cyc);
    wait_drain(100);
    @(negedge clk);
    check("release0_deb", int'(deb), 0);
    check("release0_fall_single", int'(fall), 0);

    // 5: all channels pressed together; applied a few cycles after a tick so the change is
    // seen by every channel before the next ticked pass starts
    wait_tick(40);
    repeat (5) @(posedge clk);
    drive_btn(4'b1111);
    for (int ch = 0; ch < N_BTN; ch++) expect_edge(ch, 1'b0, cyc);
    wait_drain(120);
    check("all_press_deb", int'(deb), 'b1111);
    check("rise_gap_0_1", ev_cyc[1] - ev_cyc[0], 1);
    check("rise_gap_1_2", ev_cyc[2] - ev_cyc[1], 1);
    check("rise_gap_2_3", ev_cyc[3] - ev_cyc[2], 1);

    wait_tick(40);
    repeat (5) @(posedge clk);
    drive_btn(4'b0000);
    for (int ch = 0; ch < N_BTN; ch++) expect_edge(ch, 1'b1, cyc);
    wait_drain(120);
    check("all_release_deb", int'(deb), 0);

    // 6: reset mid-count discards progress on channel 2
    drive_btn(4'b0100);
    wait_tick(40);
    wait_tick(40);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    rel = cyc;
    @(negedge clk);
    check("midreset_deb", int'(deb), 0);
    check("midreset_cnt2", int'(dut.cnt_q[2]), 0);
    expect_edge(2, 1'b0, rel);
    wait_drain(100);
    check("after_reset_deb", int'(deb), 'b0100);

    repeat (10) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
